ring_window_reader: RTL and testbench
=====================================

// Module: ring_window_reader
// PURPOSE
//  Read side of the filter's 66-entry circular sample RAM. On a start pulse from the
//  write-address generator, walks backwards from the newest written address over a
//  runtime window, drives the RAM read port, absorbs RAM read latency and accumulates a
//  signed boxcar sum of the window. Output feeds the filter post-scaling stage.
// PARAMETERS
//  DEPTH   66  ring entries; addresses 0..DEPTH-1, wrap DEPTH-1 <-> 0
//  AW      7   address width; win width is AW bits
//  DW      16  sample width, two's complement
//  RD_LAT  2   RAM read latency, cycles from rden/rd_addr to valid rd_data (>=1)
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       asynchronous active-low reset
//  start        in   1       1-cycle pulse: newest sample committed at base_addr
//  base_addr    in   AW      address of newest sample
//  win          in   AW      window length; 0 -> 1, >DEPTH -> DEPTH
//  rden         out  1       RAM read enable
//  rd_addr      out  AW      RAM read address
//  rd_data      in   DW      RAM read data, valid RD_LAT cycles after rden
//  sum_out      out  DW+AW   signed window sum, held until next result
//  sum_valid    out  1       1-cycle pulse, sum_out updated
//  busy         out  1       high from cycle after accepted start through sum_valid cycle
//  overrun      out  1       sticky: start seen while busy
//  clr_overrun  in   1       clears overrun; start-while-busy in same cycle wins (stays 1)
// BEHAVIOUR
//  Reset: rden=0, rd_addr=0, sum_out=0, sum_valid=0, busy=0, overrun=0, state=IDLE,
//   accumulator=0, latency tag pipe=0. Async assert, sync release.
//  All outputs registered.
//  FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//   IDLE: start sampled high -> latch ptr=base_addr (>=DEPTH -> DEPTH-1), cnt=clamped win,
//     acc=0 -> ISSUE.
//   ISSUE: rden=1, rd_addr=ptr each cycle; ptr <= (ptr==0) ? DEPTH-1 : ptr-1; cnt-1.
//     After cnt reads -> DRAIN.
//   DRAIN: rden=0; wait until the tag pipe is empty -> DONE.
//   DONE: sum_out<=acc, sum_valid=1 for one cycle -> IDLE.
//  Reads are back-to-back, one per cycle, no gaps.
//  Latency tag: RD_LAT-deep shift register of rden. When its tail is 1, acc += sign-ext(rd_data).
//  Timing, start sampled at edge E0:
//   - rden high for cycles 1..win;
//   - last data accumulated at end of cycle win+RD_LAT;
//   - sum_valid high in cycle win+RD_LAT+1;
//   - busy low again in the cycle after sum_valid.
//  Width: acc is DW+AW signed. Max |sum| = DEPTH*2^(DW-1) < 2^(DW+AW-1), so no overflow.
//  start while busy: ignored, set overrun; the in-flight result is unaffected.
//  start in the DONE cycle counts as busy (ignored + overrun).
//  start in the cycle after sum_valid is accepted.
//  Address sequence always stays in 0..DEPTH-1; wrap is applied per decrement.
//  Reset mid-operation: everything returns to reset values. No sum_valid after release.
//   RAM data still returning from earlier reads is ignored (tag pipe cleared).
// STRUCTURE
//  filter_pkg: RING_DEPTH=66, RING_AW=7, SAMPLE_DW=16; state enum
//   {IDLE, ISSUE, DRAIN, DONE}; function ring_dec(ptr) for the wrap decrement.
//   The write-address generator uses the same ring_dec and constants.
//  No sub-module: FSM, pointer, tag pipe and accumulator sit in one file.
//  Bench supplies a synchronous RAM model with RD_LAT.
// TESTING (DEPTH=66, DW=16, RD_LAT=2)
//  1 base=10, win=4, RAM[10,9,8,7]=1,2,3,4
//    -> rd_addr 10,9,8,7 in cycles 1-4; sum_valid in cycle 7; sum_out=10.
//  2 base=1, win=3, RAM[1,0,65]=5,-2,7 -> rd_addr 1,0,65; sum_out=10.
//  3 win=0 -> one read at base. win=100 -> 66 reads, each address exactly once.
//  4 all 66 entries=-32768, win=66 -> sum_out=-2162688; 66,32767 entries -> 2162622.
//  5 second start in cycle 3 of test 1 -> ignored, overrun=1, sum_out still 10;
//    clr_overrun -> overrun=0.
//  6 rst_n low in cycle 2 of test 1 -> all outputs 0; no sum_valid in the 10 cycles after
//    release; next start gives a correct sum.

Source files
------------

// File: rtl/filter_pkg.sv
// filter_pkg: ring geometry, reader FSM states and the wrap decrement
// shared by the read and write address generators of the filter ring RAM.
package filter_pkg;
    localparam int RING_DEPTH = 66;
    localparam int RING_AW    = 7;
    localparam int SAMPLE_DW  = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    function automatic logic [RING_AW-1:0] ring_dec(input logic [RING_AW-1:0] ptr);
        return (ptr == '0) ? RING_AW'(RING_DEPTH - 1) : ptr - 1'b1;
    endfunction
endpackage

// File: rtl/ring_window_reader.sv
// ring_window_reader: walks the ring backwards from the newest sample over a
// runtime window, absorbs RAM read latency and emits the signed boxcar sum.
module ring_window_reader
    import filter_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [RING_AW-1:0]                   base_addr,
    input  logic [RING_AW-1:0]                   win,
    output logic                                 rden,
    output logic [RING_AW-1:0]                   rd_addr,
    input  logic [SAMPLE_DW-1:0]                 rd_data,
    output logic signed [SAMPLE_DW+RING_AW-1:0]  sum_out,
    output logic                                 sum_valid,
    output logic                                 busy,
    output logic                                 overrun,
    input  logic                                 clr_overrun
);
    localparam int SW = SAMPLE_DW + RING_AW;

    state_t              state, state_n;
    logic [RING_AW-1:0]  ptr, ptr_n, cnt, cnt_n, rd_addr_n, base_c, win_c;
    logic [RD_LAT-1:0]   tag;
    logic [RD_LAT:0]     tag_sh;
    logic signed [SW-1:0] acc, acc_n, acc_add, sum_n;
    logic                rden_n, sum_valid_n, busy_n, overrun_n;

    assign base_c  = (base_addr >= RING_AW'(RING_DEPTH)) ? RING_AW'(RING_DEPTH - 1) : base_addr;
    assign win_c   = (win == '0) ? RING_AW'(1) :
                     (win > RING_AW'(RING_DEPTH)) ? RING_AW'(RING_DEPTH) : win;
    // Low RD_LAT bits are the tag pipe as it will be after this edge.
    assign tag_sh  = {tag, rden};
    assign acc_add = acc + (tag[RD_LAT-1] ? SW'($signed(rd_data)) : '0);

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        cnt_n       = cnt;
        rden_n      = 1'b0;
        rd_addr_n   = rd_addr;
        acc_n       = acc_add;
        sum_n       = sum_out;
        sum_valid_n = 1'b0;
        busy_n      = busy;
        overrun_n   = (start && busy) || (overrun && !clr_overrun);
        case (state)
            IDLE: if (start) begin
                state_n   = ISSUE;
                rden_n    = 1'b1;
                rd_addr_n = base_c;
                ptr_n     = ring_dec(base_c);
                cnt_n     = win_c;
                acc_n     = '0;
                busy_n    = 1'b1;
            end
            ISSUE: if (cnt == RING_AW'(1)) begin
                state_n = DRAIN;
            end else begin
                rden_n    = 1'b1;
                rd_addr_n = ptr;
                ptr_n     = ring_dec(ptr);
                cnt_n     = cnt - 1'b1;
            end
            // Finish on the cycle the last tagged word is being accumulated.
            DRAIN: if (tag_sh[RD_LAT-1:0] == '0) begin
                state_n     = DONE;
                sum_n       = acc_add;
                sum_valid_n = 1'b1;
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            tag       <= '0;
            acc       <= '0;
            rden      <= 1'b0;
            rd_addr   <= '0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            tag       <= tag_sh[RD_LAT-1:0];
            acc       <= acc_n;
            rden      <= rden_n;
            rd_addr   <= rd_addr_n;
            sum_out   <= sum_n;
            sum_valid <= sum_valid_n;
            busy      <= busy_n;
            overrun   <= overrun_n;
        end
    end
endmodule

// File: tb/tb_ring_window_reader.sv
// tb_ring_window_reader: ring RAM model plus a cycle-indexed reference of one
// window read, compared against the reader every cycle, with directed and random starts.
module tb_ring_window_reader;
    localparam int L = 2;
    localparam int D = 66;

    logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, clr_overrun = 1'b0;
    logic [6:0]        base_addr = '0, win = '0, rd_addr;
    logic              rden, sum_valid, busy, overrun;
    logic [15:0]       rd_data;
    logic signed [22:0] sum_out;

    ring_window_reader #(.RD_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .win(win),
        .rden(rden), .rd_addr(rd_addr), .rd_data(rd_data), .sum_out(sum_out),
        .sum_valid(sum_valid), .busy(busy), .overrun(overrun), .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with L cycles of read latency; idle slots return junk.
    logic [15:0] ram [D];
    logic [15:0] rp [L];
    always @(posedge clk) begin
        rp[0] <= rden ? ram[rd_addr] : 16'($urandom);
        for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
    end
    assign rd_data = rp[L-1];

    int checks = 0, errors = 0;
    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference: m_cyc is the 1-based cycle index since the accepted start (0 = idle).
    int     m_cyc = 0, m_n = 1, m_base = 0;
    longint m_sum = 0, m_sum_out = 0;
    bit     m_ovr = 0, m_was_busy;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_sum_out = 0; m_ovr = 0;
        end else begin
            m_was_busy = (m_cyc != 0);
            if (start && m_was_busy) m_ovr = 1;
            else if (clr_overrun) m_ovr = 0;
            if (m_was_busy) begin
                m_cyc++;
                if (m_cyc > m_n + L + 1) m_cyc = 0;
            end else if (start) begin
                m_base = (base_addr >= D) ? D - 1 : int'(base_addr);
                m_n    = (win == 0) ? 1 : (win > D) ? D : int'(win);
                m_sum  = 0;
                for (int k = 0; k < m_n; k++) m_sum += $signed(ram[(m_base - k + D) % D]);
                m_cyc  = 1;
            end
            if (m_cyc == m_n + L + 1) m_sum_out = m_sum;
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_cyc != 0);
        chk("rden", rden, m_cyc >= 1 && m_cyc <= m_n);
        chk("sum_valid", sum_valid, m_cyc != 0 && m_cyc == m_n + L + 1);
        chk("overrun", overrun, m_ovr);
        chk("sum_out", longint'(sum_out), m_sum_out);
        if (m_cyc >= 1 && m_cyc <= m_n)
            chk("rd_addr", rd_addr, ((m_base - m_cyc + 1) % D + D) % D);
    end

    logic [6:0] aq[$];

    task automatic do_start(input int b, input int w);
        @(negedge clk); #1;
        start = 1'b1; base_addr = 7'(b); win = 7'(w);
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input int c0, output int c);
        c = c0;
        while (c < 300) begin
            if (rden) aq.push_back(rd_addr);
            if (sum_valid) break;
            @(negedge clk); #1;
            c++;
        end
        if (c >= 300) chk("timeout_sum_valid", 0, 1);
    endtask

    initial begin
        int c, ones;
        int e1[4] = '{10, 9, 8, 7};
        int e2[3] = '{1, 0, 65};
        bit seen[D];
        for (int i = 0; i < D; i++) ram[i] = 16'($urandom);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rden", rden, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_sum_out", longint'(sum_out), 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        // 1: basic window
        ram[10] = 16'd1; ram[9] = 16'd2; ram[8] = 16'd3; ram[7] = 16'd4;
        aq.delete();
        do_start(10, 4);
        wait_valid(1, c);
        chk("t1_cycle", c, 7);
        chk("t1_sum", longint'(sum_out), 10);
        chk("t1_nreads", aq.size(), 4);
        for (int i = 0; i < 4; i++) chk("t1_addr", aq[i], e1[i]);

        // 2: wrap through address 0
        ram[1] = 16'd5; ram[0] = 16'hFFFE; ram[65] = 16'd7;
        aq.delete();
        do_start(1, 3);
        wait_valid(1, c);
        chk("t2_sum", longint'(sum_out), 10);
        for (int i = 0; i < 3; i++) chk("t2_addr", aq[i], e2[i]);

        // 3: window clamps and base clamp
        aq.delete();
        do_start(20, 0);
        wait_valid(1, c);
        chk("t3_win0_nreads", aq.size(), 1);
        chk("t3_win0_addr", aq[0], 20);
        chk("t3_win0_cycle", c, 4);
        aq.delete();
        do_start(30, 100);
        wait_valid(1, c);
        chk("t3_win100_nreads", aq.size(), 66);
        foreach (seen[i]) seen[i] = 1'b0;
        foreach (aq[i]) if (aq[i] < D) seen[aq[i]] = 1'b1;
        ones = 0;
        foreach (seen[i]) ones += int'(seen[i]);
        chk("t3_win100_distinct", ones, 66);
        aq.delete();
        do_start(127, 2);
        wait_valid(1, c);
        chk("t3_base_clamp_a0", aq[0], 65);
        chk("t3_base_clamp_a1", aq[1], 64);

        // 4: extremes
        for (int i = 0; i < D; i++) ram[i] = 16'h8000;
        do_start(5, 66);
        wait_valid(1, c);
        chk("t4_min_sum", longint'(sum_out), -2162688);
        for (int i = 0; i < D; i++) ram[i] = 16'h7FFF;
        do_start(65, 66);
        wait_valid(1, c);
        chk("t4_max_sum", longint'(sum_out), 2162622);

        // 5: start while busy
        ram[10] = 16'd1; ram[9] = 16'd2; ram[8] = 16'd3; ram[7] = 16'd4;
        do_start(10, 4);
        @(negedge clk); #1;
        @(negedge clk); #1;
        start = 1'b1; base_addr = 7'd50;
        @(negedge clk); #1;
        start = 1'b0;
        wait_valid(4, c);
        chk("t5_cycle", c, 7);
        chk("t5_sum", longint'(sum_out), 10);
        chk("t5_overrun_set", overrun, 1);
        @(negedge clk); #1;
        clr_overrun = 1'b1;
        @(negedge clk); #1;
        clr_overrun = 1'b0;
        chk("t5_overrun_clr", overrun, 0);

        // 6: reset mid-operation
        do_start(10, 4);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rden", rden, 0);
        chk("t6_busy", busy, 0);
        chk("t6_sum_out", longint'(sum_out), 0);
        chk("t6_overrun", overrun, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        ones = 0;
        repeat (10) begin
            @(negedge clk); #1;
            ones += int'(sum_valid);
        end
        chk("t6_no_valid", ones, 0);
        do_start(10, 4);
        wait_valid(1, c);
        chk("t6_sum", longint'(sum_out), 10);

        // Random: fixed RAM contents, random starts, clears and windows
        for (int i = 0; i < D; i++) ram[i] = 16'($urandom);
        repeat (3000) begin
            @(negedge clk); #1;
            start       = ($urandom_range(0, 9) == 0);
            clr_overrun = ($urandom_range(0, 15) == 0);
            base_addr   = 7'($urandom_range(0, 127));
            win         = 7'($urandom_range(0, 127));
        end
        start = 1'b0; clr_overrun = 1'b0;
        repeat (200) @(negedge clk);
        #1;
        chk("final_idle", busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
